seq_branch_compare_unit: RTL and testbench

- Multi-cycle compare/branch-resolution unit in the execute stage of the sequential RISC-V core.
- Consumes rs1/rs2 plus funct3 and produces the SLT/SLTU writeback value or the branch-taken decision.
- Compares MSB-first, CHUNK bits per cycle: an iterative form of the bitwise less-than chain, sized to keep the critical path short.
- Sits between operand fetch (valid/ready in) and writeback/PC-select (valid/ready out).

---
 rtl/seq_branch_compare_unit.sv | 165 ++++++++++++++++
 tb/tb_seq_branch_compare_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_branch_compare_unit.sv
// seq_branch_compare_unit
// Iterative compare/branch-resolution unit for the execute stage.
// Operands are compared MSB-first, CHUNK bits per cycle. Signed compares are
// turned into unsigned ones by flipping the sign bit of both operands at
// capture. The result is registered and then held until the consumer takes it.
module seq_branch_compare_unit #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] set_val,
    output logic            is_branch
);

    localparam int N     = XLEN / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_BLT  = 3'b100;
    localparam logic [2:0] OP_BGE  = 3'b101;
    localparam logic [2:0] OP_BLTU = 3'b110;
    localparam logic [2:0] OP_BGEU = 3'b111;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lt_f;
    logic             r_gt_f;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic             r_taken;
    logic [XLEN-1:0]  r_set_val;
    logic             r_is_branch;

    logic             w_signed_in;
    logic [XLEN-1:0]  w_sign_flip;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_lt_nxt;
    logic             w_gt_nxt;
    logic             w_eq;
    logic             w_last;
    logic             w_taken;
    logic [XLEN-1:0]  w_set_val;
    logic             w_is_branch;

    // Signed compares map to unsigned order by inverting the MSB of both operands
    assign w_signed_in = (op == OP_SLT) || (op == OP_BLT) || (op == OP_BGE);
    assign w_sign_flip = {w_signed_in, {(XLEN-1){1'b0}}};

    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign taken     = r_taken;
    assign set_val   = r_set_val;
    assign is_branch = r_is_branch;

    // Select the chunk addressed by the counter, most significant chunk first
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_chunk = r_a[XLEN-1-i*CHUNK -: CHUNK];
                w_b_chunk = r_b[XLEN-1-i*CHUNK -: CHUNK];
            end
        end
    end

    // First differing chunk decides the order; later chunks cannot change it
    always_comb begin
        w_lt_nxt = r_lt_f;
        w_gt_nxt = r_gt_f;
        if (!r_lt_f && !r_gt_f) begin
            w_lt_nxt = (w_a_chunk < w_b_chunk);
            w_gt_nxt = (w_a_chunk > w_b_chunk);
        end
    end

    // Final result from the flags as they stand after the current chunk
    always_comb begin
        w_eq        = !w_lt_nxt && !w_gt_nxt;
        w_taken     = 1'b0;
        w_set_val   = '0;
        w_is_branch = 1'b1;
        case (r_op)
            OP_BEQ:           w_taken = w_eq;
            OP_BNE:           w_taken = !w_eq;
            OP_SLT, OP_SLTU: begin
                w_set_val   = XLEN'(w_lt_nxt);
                w_is_branch = 1'b0;
            end
            OP_BLT, OP_BLTU:  w_taken = w_lt_nxt;
            OP_BGE, OP_BGEU:  w_taken = !w_lt_nxt;
            default:          w_taken = 1'b0;
        endcase
    end

    // Operand/opcode capture on acceptance; pure data, no reset needed
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && in_valid) begin
            r_op <= op;
            r_a  <= rs1 ^ w_sign_flip;
            r_b  <= rs2 ^ w_sign_flip;
        end
    end

    // Control FSM: accept, iterate over N chunks, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lt_f      <= 1'b0;
            r_gt_f      <= 1'b0;
            r_taken     <= 1'b0;
            r_set_val   <= '0;
            r_is_branch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt   <= '0;
                        r_lt_f  <= 1'b0;
                        r_gt_f  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_lt_f <= w_lt_nxt;
                    r_gt_f <= w_gt_nxt;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_taken     <= w_taken;
                        r_set_val   <= w_set_val;
                        r_is_branch <= w_is_branch;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_branch_compare_unit.sv
// tb_seq_branch_compare_unit
// Directed-vector bench for the iterative compare/branch unit.
module tb_seq_branch_compare_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] set_val;
    logic            is_branch;

    int n_checks = 0;
    int n_fail   = 0;

    seq_branch_compare_unit #(.XLEN(64), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .set_val   (set_val),
        .is_branch (is_branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, confirm 8-edge latency, result, optional hold, and release
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input int hold, input logic exp_taken,
                         input logic [63:0] exp_set, input logic exp_br);
        int lat;
        @(negedge clk);
        op        = f3;
        rs1       = a;
        rs2       = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs and keep in_valid up briefly: none of it may matter now
        rs1 = ~a;
        rs2 = ~b;
        op  = ~f3;
        check({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'd8);
        check({tag, ".taken"}, 64'(taken), 64'(exp_taken));
        check({tag, ".set_val"}, set_val, exp_set);
        check({tag, ".is_branch"}, 64'(is_branch), 64'(exp_br));
        check({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_taken"}, 64'(taken), 64'(exp_taken));
            check({tag, ".hold_set"}, set_val, exp_set);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".release_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".release_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'b000;
        rs1       = '0;
        rs2       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.in_ready",  64'(in_ready),  64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.taken",     64'(taken),     64'd0);
        check("reset.set_val",   set_val,        64'd0);
        check("reset.is_branch", 64'(is_branch), 64'd0);

        // SLTU / SLT with 1 vs all-ones: unsigned 1 < max, signed 1 > -1
        do_op("sltu", 3'b011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'd1, 1'b0);
        do_op("slt",  3'b010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'd0, 1'b0);
        // SLT -2 < -1
        do_op("slt_neg", 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'd1, 1'b0);

        // Equal operands
        do_op("beq", 3'b000, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1'b1, 64'd0, 1'b1);
        do_op("bne", 3'b001, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0, 64'd0, 1'b1);
        do_op("blt_eq", 3'b100, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0, 64'd0, 1'b1);

        // Bit-0-only difference resolves in the last chunk
        do_op("bltu_b0", 3'b110, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'd0, 1'b1);
        do_op("bgeu_b0", 3'b111, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 64'd0, 1'b1);
        do_op("bne_b0",  3'b001, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 0, 1'b1, 64'd0, 1'b1);

        // MSB-only difference: signed and unsigned disagree
        do_op("bltu_msb", 3'b110, 64'h8000_0000_0000_0000, 64'd0, 0, 1'b0, 64'd0, 1'b1);
        do_op("bge_msb",  3'b101, 64'd0, 64'h8000_0000_0000_0000, 0, 1'b1, 64'd0, 1'b1);

        // Backpressure: result held for 5 cycles
        do_op("bp_bltu", 3'b110, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b1, 64'd0, 1'b1);

        // Reset during RUN at cnt=3: operation discarded
        @(negedge clk);
        op       = 3'b011;
        rs1      = 64'd1;
        rs2      = 64'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst.no_valid", 64'(seen), 64'd0);
        check("midrst.in_ready_after", 64'(in_ready), 64'd1);
        do_op("blt_after_rst", 3'b100, 64'h8000_0000_0000_0000, 64'd0, 0, 1'b1, 64'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
